// File: rtl/fir_pkg.sv
// Shared constants and state encoding for the streaming FIR sequencer.
package fir_pkg;
    localparam int TAP_NUM      = 11;
    localparam int MAC_CYCLES   = 12;
    localparam int CLEAR_CYCLES = 11;
    localparam int IDX_W        = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_WAIT_IN,
        ST_MAC,
        ST_OUT,
        ST_DONE
    } state_t;
endpackage

// File: rtl/fir_ring_addr.sv
// Circular-buffer write pointer and the mod-TAPS "k samples ago" read index.
module fir_ring_addr
    import fir_pkg::*;
#(
    parameter int TAPS = TAP_NUM
) (
    input  logic             clk,
    input  logic             rst_n_i,
    input  logic             clr_i,
    input  logic             adv_i,
    input  logic [IDX_W-1:0] k_i,
    output logic [IDX_W-1:0] wptr_o,
    output logic [IDX_W-1:0] idx_o
);
    logic [IDX_W-1:0] wptr_q, wptr_d;

    always_comb begin
        wptr_d = wptr_q;
        if (clr_i) begin
            wptr_d = '0;
        end else if (adv_i) begin
            wptr_d = (wptr_q == IDX_W'(TAPS - 1)) ? '0 : wptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n_i) begin
            wptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
        end
    end

    // Going back past index 0 wraps to the top of the buffer.
    always_comb begin
        if (wptr_q >= k_i) begin
            idx_o = wptr_q - k_i;
        end else begin
            idx_o = wptr_q + IDX_W'(TAPS) - k_i;
        end
    end

    assign wptr_o = wptr_q;
endmodule

// File: rtl/fir_stream_engine.sv
// Sequences sample writes, the 11-tap multiply-accumulate sweep over both BRAMs,
// and the AXI-Stream handshakes for one FIR run of data_length samples.
module fir_stream_engine
    import fir_pkg::*;
#(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int Tap_Num     = 11
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    input  logic                   ap_start,
    input  logic [31:0]            data_length,
    output logic                   ap_idle,
    output logic                   ap_done,
    input  logic                   ss_tvalid,
    input  logic [pDATA_WIDTH-1:0] ss_tdata,
    input  logic                   ss_tlast,
    output logic                   ss_tready,
    input  logic                   sm_tready,
    output logic                   sm_tvalid,
    output logic [pDATA_WIDTH-1:0] sm_tdata,
    output logic                   sm_tlast,
    output logic                   tap_EN,
    output logic [3:0]             tap_WE,
    output logic [pADDR_WIDTH-1:0] tap_A,
    input  logic [pDATA_WIDTH-1:0] tap_Do,
    output logic                   data_EN,
    output logic [3:0]             data_WE,
    output logic [pADDR_WIDTH-1:0] data_A,
    output logic [pDATA_WIDTH-1:0] data_Di,
    input  logic [pDATA_WIDTH-1:0] data_Do
);
    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       cnt_q, cnt_d;
    logic [31:0]            count_q, count_d;
    logic [31:0]            len_q, len_d;
    logic [pDATA_WIDTH-1:0] acc_q, acc_d;
    logic                   wp_clr, wp_adv;
    logic [IDX_W-1:0]       wptr, rd_idx;
    logic                   is_last;
    logic                   unused_tlast;

    // The run length alone terminates processing.
    assign unused_tlast = ss_tlast;
    assign is_last      = (count_q == len_q - 32'd1);

    fir_ring_addr #(.TAPS(Tap_Num)) u_ring (
        .clk     (axis_clk),
        .rst_n_i (axis_rst_n),
        .clr_i   (wp_clr),
        .adv_i   (wp_adv),
        .k_i     (cnt_q),
        .wptr_o  (wptr),
        .idx_o   (rd_idx)
    );

    function automatic logic [pADDR_WIDTH-1:0] byte_addr(input logic [IDX_W-1:0] idx);
        return {{(pADDR_WIDTH-IDX_W-2){1'b0}}, idx, 2'b00};
    endfunction

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        count_d   = count_q;
        len_d     = len_q;
        acc_d     = acc_q;
        wp_clr    = 1'b0;
        wp_adv    = 1'b0;
        ap_idle   = 1'b0;
        ap_done   = 1'b0;
        ss_tready = 1'b0;
        sm_tvalid = 1'b0;
        sm_tdata  = '0;
        sm_tlast  = 1'b0;
        tap_EN    = 1'b0;
        tap_WE    = 4'h0;
        tap_A     = '0;
        data_EN   = 1'b0;
        data_WE   = 4'h0;
        data_A    = '0;
        data_Di   = '0;
        case (state_q)
            ST_IDLE: begin
                ap_idle = 1'b1;
                if (ap_start) begin
                    len_d   = data_length;
                    count_d = '0;
                    cnt_d   = '0;
                    wp_clr  = 1'b1;
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                data_EN = 1'b1;
                data_WE = 4'hF;
                data_A  = byte_addr(cnt_q);
                if (cnt_q == IDX_W'(CLEAR_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = (len_q == 32'd0) ? ST_DONE : ST_WAIT_IN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT_IN: begin
                ss_tready = 1'b1;
                if (ss_tvalid) begin
                    data_EN = 1'b1;
                    data_WE = 4'hF;
                    data_A  = byte_addr(wptr);
                    data_Di = ss_tdata;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_MAC;
                end
            end
            ST_MAC: begin
                if (cnt_q <= IDX_W'(Tap_Num - 1)) begin
                    tap_EN  = 1'b1;
                    tap_A   = byte_addr(cnt_q);
                    data_EN = 1'b1;
                    data_A  = byte_addr(rd_idx);
                end
                // Read data lags the address by one cycle, so pair k-1 lands at step k.
                if (cnt_q != '0) begin
                    acc_d = acc_q + data_Do * tap_Do;
                end
                if (cnt_q == IDX_W'(MAC_CYCLES - 1)) begin
                    wp_adv  = 1'b1;
                    state_d = ST_OUT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_OUT: begin
                sm_tvalid = 1'b1;
                sm_tdata  = acc_q;
                sm_tlast  = is_last;
                if (sm_tready) begin
                    count_d = count_q + 32'd1;
                    state_d = is_last ? ST_DONE : ST_WAIT_IN;
                end
            end
            ST_DONE: begin
                ap_done = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge axis_clk) begin
        if (!axis_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            count_q <= '0;
            len_q   <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            count_q <= count_d;
            len_q   <= len_d;
            acc_q   <= acc_d;
        end
    end
endmodule

// File: tb/tb_fir_stream_engine.sv
// Directed bench for fir_stream_engine with behavioural tap and data BRAMs.
module tb_fir_stream_engine;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        ap_start;
    logic [31:0] data_length;
    logic        ap_idle, ap_done;
    logic        ss_tvalid, ss_tlast, ss_tready;
    logic [31:0] ss_tdata;
    logic        sm_tready, sm_tvalid, sm_tlast;
    logic [31:0] sm_tdata;
    logic        tap_EN, data_EN;
    logic [3:0]  tap_WE, data_WE;
    logic [11:0] tap_A, data_A;
    logic [31:0] tap_Do, data_Do, data_Di;

    logic [31:0] tap_mem  [0:15];
    logic [31:0] data_mem [0:15];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fir_stream_engine dut (
        .axis_clk    (clk),
        .axis_rst_n  (rst_n),
        .ap_start    (ap_start),
        .data_length (data_length),
        .ap_idle     (ap_idle),
        .ap_done     (ap_done),
        .ss_tvalid   (ss_tvalid),
        .ss_tdata    (ss_tdata),
        .ss_tlast    (ss_tlast),
        .ss_tready   (ss_tready),
        .sm_tready   (sm_tready),
        .sm_tvalid   (sm_tvalid),
        .sm_tdata    (sm_tdata),
        .sm_tlast    (sm_tlast),
        .tap_EN      (tap_EN),
        .tap_WE      (tap_WE),
        .tap_A       (tap_A),
        .tap_Do      (tap_Do),
        .data_EN     (data_EN),
        .data_WE     (data_WE),
        .data_A      (data_A),
        .data_Di     (data_Di),
        .data_Do     (data_Do)
    );

    always @(posedge clk) begin
        if (tap_EN) tap_Do <= tap_mem[tap_A[5:2]];
        if (data_EN) begin
            if (data_WE == 4'hF) data_mem[data_A[5:2]] <= data_Di;
            data_Do <= data_mem[data_A[5:2]];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [31:0] len);
        data_length = len;
        ap_start    = 1'b1;
        tick();
        ap_start    = 1'b0;
    endtask

    task automatic send(input logic [31:0] v, output logic [11:0] wa);
        bit ok;
        ok = 1'b0;
        wa = '0;
        ss_tdata  = v;
        ss_tvalid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (ss_tready) begin
                wa = data_A;
                ok = 1'b1;
                tick();
                break;
            end
            tick();
        end
        ss_tvalid = 1'b0;
        ss_tdata  = '0;
        n_cmp++;
        if (!ok) begin
            $display("FAIL ss_handshake: got no ss_tready expected handshake for %h", v);
            n_bad++;
        end
        $display("sample %h written at byte addr %h", v, wa);
    endtask

    task automatic recv(input int stall, output logic [31:0] d, output logic l, output int lat);
        bit ok;
        int sbad;
        ok = 1'b0;
        sbad = 0;
        lat = 0;
        d = '0;
        l = 1'b0;
        sm_tready = 1'b0;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (sm_tvalid) begin
                ok = 1'b1;
                break;
            end
            tick();
            lat++;
        end
        n_cmp++;
        if (!ok) begin
            $display("FAIL sm_valid_timeout: got no sm_tvalid expected one within 200 cycles");
            n_bad++;
        end else begin
            d = sm_tdata;
            l = sm_tlast;
            for (int s = 0; s < stall; s++) begin
                tick();
                if (sm_tvalid !== 1'b1 || sm_tdata !== d || sm_tlast !== l || ss_tready !== 1'b0)
                    sbad++;
            end
            if (stall > 0) begin
                n_cmp++;
                if (sbad != 0) begin
                    $display("FAIL stall_stable: got %0d unstable cycles expected 0", sbad);
                    n_bad++;
                end
            end
            sm_tready = 1'b1;
            #1;
            tick();
            sm_tready = 1'b0;
        end
        $display("result %h last %b after %0d cycles", d, l, lat);
    endtask

    task automatic check_done();
        n_cmp++;
        if (ap_done !== 1'b1) begin
            $display("FAIL done_pulse: got ap_done=%b expected 1", ap_done);
            n_bad++;
        end
        tick();
        n_cmp++;
        if ({ap_done, ap_idle} !== 2'b01) begin
            $display("FAIL done_to_idle: got done,idle=%b expected 01", {ap_done, ap_idle});
            n_bad++;
        end
    endtask

    task automatic check_quiet(input string name);
        logic [135:0] outs;
        outs = {ap_done, ss_tready, sm_tvalid, sm_tdata, sm_tlast, tap_EN, tap_WE, tap_A,
                data_EN, data_WE, data_A, data_Di};
        n_cmp++;
        if (ap_idle !== 1'b1) begin
            $display("FAIL %s_idle: got ap_idle=%b expected 1", name, ap_idle);
            n_bad++;
        end
        n_cmp++;
        if (outs !== '0) begin
            $display("FAIL %s_outputs: got %h expected 0", name, outs);
            n_bad++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        check_quiet("reset");
        rst_n = 1'b1;
        tick();
        check_quiet("post_reset");
    endtask

    task automatic test_single();
        logic [11:0] wa;
        logic [31:0] d;
        logic l;
        int lat;
        for (int i = 0; i < 11; i++) tap_mem[i] = 32'(i + 1);
        start_run(32'd1);
        send(32'd5, wa);
        recv(0, d, l, lat);
        n_cmp++;
        if (d !== 32'd5) begin $display("FAIL single_data: got %h expected 00000005", d); n_bad++; end
        n_cmp++;
        if (l !== 1'b1) begin $display("FAIL single_last: got %b expected 1", l); n_bad++; end
        n_cmp++;
        if (lat != 12) begin $display("FAIL latency: got %0d expected 12 edges after handshake", lat); n_bad++; end
        check_done();
    endtask

    task automatic test_tap_order();
        logic [11:0] wa;
        logic [31:0] d;
        logic l;
        int lat;
        logic [31:0] exp_v [0:2];
        exp_v[0] = 32'd1;
        exp_v[1] = 32'd4;
        exp_v[2] = 32'd10;
        start_run(32'd3);
        for (int n = 0; n < 3; n++) begin
            send(32'(n + 1), wa);
            recv(0, d, l, lat);
            n_cmp++;
            if (d !== exp_v[n] || l !== (n == 2)) begin
                $display("FAIL tap_order[%0d]: got %h/%b expected %h/%b", n, d, l, exp_v[n], n == 2);
                n_bad++;
            end
        end
        check_done();
    endtask

    task automatic test_sliding();
        logic [11:0] wa;
        logic [31:0] d;
        logic l;
        int lat;
        logic [31:0] exp_v [0:14];
        exp_v = '{1, 3, 6, 10, 15, 21, 28, 36, 45, 55, 66, 77, 88, 99, 110};
        for (int i = 0; i < 11; i++) tap_mem[i] = 32'd1;
        start_run(32'd15);
        for (int n = 0; n < 15; n++) begin
            send(32'(n + 1), wa);
            if (n == 10) begin
                n_cmp++;
                if (wa !== 12'h028) begin $display("FAIL wptr_top: got %h expected 028", wa); n_bad++; end
            end
            if (n == 11) begin
                n_cmp++;
                if (wa !== 12'h000) begin $display("FAIL wptr_wrap: got %h expected 000", wa); n_bad++; end
            end
            recv(0, d, l, lat);
            n_cmp++;
            if (d !== exp_v[n] || l !== (n == 14)) begin
                $display("FAIL sliding[%0d]: got %h/%b expected %h/%b", n, d, l, exp_v[n], n == 14);
                n_bad++;
            end
        end
        check_done();
    endtask

    task automatic test_overflow();
        logic [11:0] wa;
        logic [31:0] d;
        logic l;
        int lat;
        for (int i = 0; i < 11; i++) tap_mem[i] = 32'd0;
        tap_mem[0] = 32'hFFFF_FFFE;
        start_run(32'd1);
        send(32'h7FFF_FFFF, wa);
        recv(0, d, l, lat);
        n_cmp++;
        if (d !== 32'h0000_0002) begin $display("FAIL overflow: got %h expected 00000002", d); n_bad++; end
        check_done();
    endtask

    task automatic test_back_pressure();
        logic [11:0] wa;
        logic [31:0] d;
        logic l;
        int lat;
        for (int i = 0; i < 11; i++) tap_mem[i] = 32'd1;
        start_run(32'd2);
        send(32'd3, wa);
        // A start pulse mid-run must not relatch the length.
        data_length = 32'd7;
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
        recv(20, d, l, lat);
        n_cmp++;
        if (d !== 32'd3 || l !== 1'b0) begin $display("FAIL bp_first: got %h/%b expected 00000003/0", d, l); n_bad++; end
        send(32'd4, wa);
        recv(0, d, l, lat);
        n_cmp++;
        if (d !== 32'd7 || l !== 1'b1) begin $display("FAIL bp_second: got %h/%b expected 00000007/1", d, l); n_bad++; end
        check_done();
    endtask

    task automatic test_reset_mid();
        logic [11:0] wa;
        logic [31:0] d;
        logic l;
        int lat;
        logic [31:0] exp_v [0:3];
        exp_v = '{1, 3, 6, 10};
        start_run(32'd5);
        send(32'd10, wa);
        recv(0, d, l, lat);
        send(32'd20, wa);
        recv(0, d, l, lat);
        send(32'd30, wa);
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        check_quiet("mid_reset");
        rst_n = 1'b1;
        tick();
        check_quiet("mid_release");
        start_run(32'd4);
        for (int n = 0; n < 4; n++) begin
            send(32'(n + 1), wa);
            recv(0, d, l, lat);
            n_cmp++;
            if (d !== exp_v[n] || l !== (n == 3)) begin
                $display("FAIL restart[%0d]: got %h/%b expected %h/%b", n, d, l, exp_v[n], n == 3);
                n_bad++;
            end
        end
        check_done();
    endtask

    task automatic test_zero_length();
        int clr, done, tv, rdy;
        clr = 0; done = 0; tv = 0; rdy = 0;
        start_run(32'd0);
        for (int i = 0; i < 30; i++) begin
            if (data_EN && data_WE == 4'hF && data_Di == 32'd0) clr++;
            if (ap_done) done++;
            if (sm_tvalid) tv++;
            if (ss_tready) rdy++;
            tick();
        end
        n_cmp++;
        if (clr != 11) begin $display("FAIL zero_clear: got %0d cycles expected 11", clr); n_bad++; end
        n_cmp++;
        if (done != 1) begin $display("FAIL zero_done: got %0d pulses expected 1", done); n_bad++; end
        n_cmp++;
        if (tv != 0 || rdy != 0) begin $display("FAIL zero_stream: got tvalid=%0d tready=%0d expected 0/0", tv, rdy); n_bad++; end
        n_cmp++;
        if (ap_idle !== 1'b1) begin $display("FAIL zero_idle: got %b expected 1", ap_idle); n_bad++; end
    endtask

    initial begin
        rst_n = 1'b0;
        ap_start = 1'b0;
        data_length = '0;
        ss_tvalid = 1'b0;
        ss_tdata = '0;
        ss_tlast = 1'b0;
        sm_tready = 1'b0;
        for (int i = 0; i < 16; i++) tap_mem[i] = '0;
        test_reset();
        test_single();
        test_tap_order();
        test_sliding();
        test_overflow();
        test_back_pressure();
        test_reset_mid();
        test_zero_length();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
